pc_gen_mt: RTL and testbench

Parametrised multi-hart program-counter generator for the fetch front end. It holds one PC per hardware thread (barrel-style) and picks the next enabled hart round-robin. It presents one fetch address per cycle on a registered valid/ready output slot. It accepts per-hart redirects (branch/jump/trap) with alignment checking, and replaces the single-thread hold/increment PC register.

---
 rtl/pc_pkg.sv | 15 +
 rtl/rr_pick.sv | 24 ++
 rtl/pc_gen_mt.sv | 97 +++++++++
 tb/tb_pc_gen_mt.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared fetch-front-end types and defaults for the multi-hart PC generator.
package pc_pkg;

   localparam int AddrW = 32;
   localparam int HartIdW = 2;

   typedef logic [AddrW-1:0] InstAddrBus;
   typedef logic [HartIdW-1:0] hart_id_t;

   localparam InstAddrBus CpuResetAddr = 32'h0000_0000;
   localparam logic RstEnable = 1'b0;
   localparam int StepDef = 4;
   localparam int AlignBitsDef = 2;

endpackage

// File: rtl/rr_pick.sv
// Round-robin find-first: first set bit of en searching upward from last+1.
module rr_pick #(
   parameter int N = 4,
   parameter int HW = 2
) (
   input  logic [N-1:0]  en,
   input  logic [HW-1:0] last,
   output logic          found,
   output logic [HW-1:0] idx
);

   // Walk from the farthest candidate down so the nearest one wins.
   always_comb begin
      found = 1'b0;
      idx = '0;
      for (int i = N; i >= 1; i--) begin
         if (en[(int'(last) + i) % N]) begin
            found = 1'b1;
            idx = HW'((int'(last) + i) % N);
         end
      end
   end

endmodule

// File: rtl/pc_gen_mt.sv
// Multi-hart PC generator: one PC per hart, round-robin issue into a
// registered valid/ready fetch slot, with aligned per-hart redirects.
module pc_gen_mt
   import pc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int NUM_HARTS = 4,
   parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(CpuResetAddr),
   parameter int STEP = StepDef,
   parameter int ALIGN_BITS = AlignBitsDef,
   localparam int HID_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_HARTS-1:0] hart_en,
   input  logic                 redirect_valid,
   input  logic [HID_W-1:0]     redirect_hart,
   input  logic [ADDR_W-1:0]    redirect_addr,
   output logic                 redirect_err,
   output logic                 fetch_valid,
   input  logic                 fetch_ready,
   output logic [ADDR_W-1:0]    fetch_pc,
   output logic [HID_W-1:0]     fetch_hart
);

   localparam logic [ADDR_W-1:0] AlignMask =
      ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [ADDR_W-1:0] StepV = ADDR_W'(STEP);
   localparam logic [HID_W-1:0] LastInit = HID_W'(NUM_HARTS - 1);

   logic [ADDR_W-1:0] pc [NUM_HARTS];
   logic [HID_W-1:0]  rr_last;
   logic              fire;
   logic              load;
   logic              found;
   logic [HID_W-1:0]  pick;
   logic              in_range;
   logic              aligned;
   logic              rd_ok;
   logic              rd_mis;
   logic              issue;
   logic              bypass;

   rr_pick #(
      .N  (NUM_HARTS),
      .HW (HID_W)
   ) u_pick (
      .en    (hart_en),
      .last  (rr_last),
      .found (found),
      .idx   (pick)
   );

   assign fire = fetch_valid & fetch_ready;
   assign load = ~fetch_valid | fire;
   assign issue = load & found;
   assign in_range = {1'b0, redirect_hart} < (HID_W+1)'(NUM_HARTS);
   assign aligned = (redirect_addr & AlignMask) == '0;
   assign rd_ok = redirect_valid & in_range & aligned;
   assign rd_mis = redirect_valid & in_range & ~aligned;
   assign bypass = rd_ok & (redirect_hart == pick);

   always_ff @(posedge clk) begin
      if (rst_n == RstEnable) begin
         fetch_valid <= 1'b0;
         fetch_pc <= RESET_ADDR;
         fetch_hart <= '0;
         redirect_err <= 1'b0;
         rr_last <= LastInit;
         for (int h = 0; h < NUM_HARTS; h++) pc[h] <= RESET_ADDR;
      end else begin
         redirect_err <= rd_mis;
         if (load) begin
            fetch_valid <= found;
            if (found) begin
               fetch_hart <= pick;
               fetch_pc <= bypass ? redirect_addr : pc[pick];
               rr_last <= pick;
            end
         end else if (rd_ok && redirect_hart == fetch_hart) begin
            // Stalled slot of a redirected hart is stale: drop it.
            fetch_valid <= 1'b0;
         end
         for (int h = 0; h < NUM_HARTS; h++) begin
            if (rd_ok && redirect_hart == HID_W'(h)) begin
               if (issue && pick == HID_W'(h))
                  pc[h] <= redirect_addr + StepV;
               else
                  pc[h] <= redirect_addr;
            end else if (issue && pick == HID_W'(h)) begin
               pc[h] <= pc[h] + StepV;
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_gen_mt.sv
// Directed table-driven bench for pc_gen_mt with default parameters.
module tb_pc_gen_mt;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  hart_en;
   logic        redirect_valid;
   logic [1:0]  redirect_hart;
   logic [31:0] redirect_addr;
   logic        redirect_err;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic [1:0]  fetch_hart;

   always #5 clk = ~clk;

   pc_gen_mt dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .hart_en        (hart_en),
      .redirect_valid (redirect_valid),
      .redirect_hart  (redirect_hart),
      .redirect_addr  (redirect_addr),
      .redirect_err   (redirect_err),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .fetch_pc       (fetch_pc),
      .fetch_hart     (fetch_hart)
   );

   typedef struct {
      logic [3:0]  en;
      logic        rdy;
      logic        rv;
      logic [1:0]  rh;
      logic [31:0] ra;
      logic        v;
      logic [31:0] pc;
      logic [1:0]  h;
      logic        err;
   } vec_t;

   vec_t tbl[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] en, input logic rdy,
                               input logic rv, input logic [1:0] rh,
                               input logic [31:0] ra, input logic v,
                               input logic [1:0] h, input logic [31:0] pc,
                               input logic err);
      vec_t t;
      t.en = en; t.rdy = rdy; t.rv = rv; t.rh = rh; t.ra = ra;
      t.v = v; t.h = h; t.pc = pc; t.err = err;
      tbl.push_back(t);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic slot(input string n, input logic v, input logic [1:0] h,
                       input logic [31:0] pc);
      chk({n, " valid"}, 32'(fetch_valid), 32'(v));
      if (v) begin
         chk({n, " hart"}, 32'(fetch_hart), 32'(h));
         chk({n, " pc"}, fetch_pc, pc);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      hart_en = 4'hF;
      fetch_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_hart = 2'd0;
      redirect_addr = 32'h0;

      // Round-robin over all four harts
      add(4'hF,1,0,0,0, 1,0,32'h0,0);
      add(4'hF,1,0,0,0, 1,1,32'h0,0);
      add(4'hF,1,0,0,0, 1,2,32'h0,0);
      add(4'hF,1,0,0,0, 1,3,32'h0,0);
      add(4'hF,1,0,0,0, 1,0,32'h4,0);
      add(4'hF,1,0,0,0, 1,1,32'h4,0);
      add(4'hF,1,0,0,0, 1,2,32'h4,0);
      // Stall three cycles
      add(4'hF,0,0,0,0, 1,2,32'h4,0);
      add(4'hF,0,0,0,0, 1,2,32'h4,0);
      add(4'hF,0,0,0,0, 1,2,32'h4,0);
      add(4'hF,1,0,0,0, 1,3,32'h4,0);
      add(4'hF,1,0,0,0, 1,0,32'h8,0);
      // Squash of a stalled slot by its own redirect
      add(4'hF,1,0,0,0, 1,1,32'h8,0);
      add(4'hF,0,1,1,32'h100, 0,1,32'h8,0);
      add(4'hF,1,0,0,0, 1,2,32'h8,0);
      add(4'hF,1,0,0,0, 1,3,32'h8,0);
      add(4'hF,1,0,0,0, 1,0,32'hC,0);
      add(4'hF,1,0,0,0, 1,1,32'h100,0);
      add(4'hF,1,0,0,0, 1,2,32'hC,0);
      add(4'hF,1,0,0,0, 1,3,32'hC,0);
      add(4'hF,1,0,0,0, 1,0,32'h10,0);
      add(4'hF,1,0,0,0, 1,1,32'h104,0);
      // Misaligned redirect
      add(4'hF,1,1,0,32'h102, 1,2,32'h10,1);
      add(4'hF,1,0,0,0, 1,3,32'h10,0);
      add(4'hF,1,0,0,0, 1,0,32'h14,0);
      // Partial enable, then none
      add(4'h5,1,0,0,0, 1,2,32'h14,0);
      add(4'h5,1,0,0,0, 1,0,32'h18,0);
      add(4'h5,1,0,0,0, 1,2,32'h18,0);
      add(4'h5,1,0,0,0, 1,0,32'h1C,0);
      add(4'h0,0,0,0,0, 1,0,32'h1C,0);
      add(4'h0,1,0,0,0, 0,0,32'h0,0);
      add(4'h0,1,0,0,0, 0,0,32'h0,0);
      add(4'hF,1,0,0,0, 1,1,32'h108,0);
      add(4'hF,1,0,0,0, 1,2,32'h1C,0);
      add(4'hF,1,0,0,0, 1,3,32'h14,0);
      // Wrap at the top of the address space
      add(4'hF,1,1,3,32'hFFFF_FFFC, 1,0,32'h20,0);
      add(4'hF,1,0,0,0, 1,1,32'h10C,0);
      add(4'hF,1,0,0,0, 1,2,32'h20,0);
      add(4'hF,1,0,0,0, 1,3,32'hFFFF_FFFC,0);
      add(4'hF,1,0,0,0, 1,0,32'h24,0);
      add(4'hF,1,0,0,0, 1,1,32'h110,0);
      add(4'hF,1,0,0,0, 1,2,32'h24,0);
      add(4'hF,1,0,0,0, 1,3,32'h0,0);
      // Same-edge bypass into the slot being loaded
      add(4'hF,1,1,0,32'h200, 1,0,32'h200,0);
      add(4'hF,1,0,0,0, 1,1,32'h114,0);
      add(4'hF,1,0,0,0, 1,2,32'h28,0);
      add(4'hF,1,0,0,0, 1,3,32'h4,0);
      add(4'hF,1,0,0,0, 1,0,32'h204,0);

      step();
      step();
      slot("reset", 1'b0, 2'd0, 32'h0);
      chk("reset pc", fetch_pc, 32'h0);
      chk("reset hart", 32'(fetch_hart), 32'd0);
      chk("reset err", 32'(redirect_err), 32'd0);

      rst_n = 1'b1;
      foreach (tbl[i]) begin
         hart_en = tbl[i].en;
         fetch_ready = tbl[i].rdy;
         redirect_valid = tbl[i].rv;
         redirect_hart = tbl[i].rh;
         redirect_addr = tbl[i].ra;
         step();
         slot($sformatf("v%0d", i), tbl[i].v, tbl[i].h, tbl[i].pc);
         chk($sformatf("v%0d err", i), 32'(redirect_err), 32'(tbl[i].err));
      end

      // Mid-stream reset also discards a same-cycle redirect
      rst_n = 1'b0;
      redirect_valid = 1'b1;
      redirect_hart = 2'd1;
      redirect_addr = 32'h300;
      step();
      slot("midrst", 1'b0, 2'd0, 32'h0);
      chk("midrst pc", fetch_pc, 32'h0);
      chk("midrst hart", 32'(fetch_hart), 32'd0);
      rst_n = 1'b1;
      redirect_valid = 1'b0;
      step();
      slot("restart0", 1'b1, 2'd0, 32'h0);
      step();
      slot("restart1", 1'b1, 2'd1, 32'h0);
      step();
      slot("restart2", 1'b1, 2'd2, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
